// File: rtl/up_bus_fanin_pkg.sv
// Shared definitions for the up-bus response aggregator: error bit map,
// watchdog state encoding and the default read-timeout data word.
package up_bus_fanin_pkg;

  localparam int ERR_W         = 3;
  localparam int ERR_TIMEOUT   = 0;
  localparam int ERR_COLLISION = 1;
  localparam int ERR_LATE      = 2;

  localparam logic [31:0] DEF_TIMEOUT_RDATA = 32'hdead_dead;

  typedef enum logic {
    WD_IDLE = 1'b0,
    WD_WAIT = 1'b1
  } wdog_state_e;

endpackage

// File: rtl/up_bus_fanin_if.sv
// Up-bus request/response bundle between up_axi, the slave responses and
// the fan-in aggregator.
interface up_bus_fanin_if
  import up_bus_fanin_pkg::*;
#(
  parameter int NUM_SLAVES = 4
);
  logic                     up_wreq;
  logic                     up_rreq;
  logic [NUM_SLAVES-1:0]    up_wack_s;
  logic [NUM_SLAVES-1:0]    up_rack_s;
  logic [NUM_SLAVES*32-1:0] up_rdata_s;
  logic                     up_wack;
  logic                     up_rack;
  logic [31:0]              up_rdata;
  logic [ERR_W-1:0]         up_err_clr;
  logic [ERR_W-1:0]         up_err_status;

  // master: up_axi plus slave responses; slave: the aggregator
  modport master (
    output up_wreq, up_rreq, up_wack_s, up_rack_s, up_rdata_s, up_err_clr,
    input  up_wack, up_rack, up_rdata, up_err_status
  );

  modport slave (
    input  up_wreq, up_rreq, up_wack_s, up_rack_s, up_rdata_s, up_err_clr,
    output up_wack, up_rack, up_rdata, up_err_status
  );
endinterface

// File: rtl/up_bus_fanin_wdog.sv
// Per-direction response watchdog: forwards the pipelined ack while a request
// is outstanding, forces an ack on expiry and flags acks that arrive unasked.
//
//   state   | meaning
//   WD_IDLE | no request outstanding; any ack is late/spurious
//   WD_WAIT | request outstanding; counting towards TIMEOUT
module up_bus_fanin_wdog
  import up_bus_fanin_pkg::*;
#(
  parameter int TIMEOUT = 256
) (
  input  logic clk,
  input  logic rstn,
  input  logic req,
  input  logic ack_in,
  output logic ack_out,
  output logic timeout,
  output logic late
);

  if (TIMEOUT == 0) begin : g_bypass
    logic unused_bypass;
    assign unused_bypass = ^{clk, rstn, req};
    assign ack_out = ack_in;
    assign timeout = 1'b0;
    assign late    = 1'b0;
  end else begin : g_wdog
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    wdog_state_e   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        state_q <= WD_IDLE;
        cnt_q   <= '0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
      end
    end

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ack_out = 1'b0;
      timeout = 1'b0;
      late    = 1'b0;
      case (state_q)
        WD_IDLE: begin
          late = ack_in;
          if (req) begin
            state_d = WD_WAIT;
            cnt_d   = '0;
          end
        end
        WD_WAIT: begin
          cnt_d = cnt_q + 1'b1;
          // a real ack on the expiry cycle takes priority over the forced one
          if (ack_in) begin
            ack_out = 1'b1;
            state_d = WD_IDLE;
          end else if (cnt_q == CNT_LAST) begin
            ack_out = 1'b1;
            timeout = 1'b1;
            state_d = WD_IDLE;
          end
        end
        default: state_d = WD_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/up_bus_fanin.sv
// Up-bus response aggregator: OR-reduces slave acks/rdata through a 1- or
// 2-stage pipeline, guards each direction with a watchdog, keeps sticky errors.
module up_bus_fanin
  import up_bus_fanin_pkg::*;
#(
  parameter int          NUM_SLAVES    = 4,
  parameter int          PIPE_STAGES   = 1,
  parameter int          TIMEOUT       = 256,
  parameter logic [31:0] TIMEOUT_RDATA = DEF_TIMEOUT_RDATA
) (
  input logic           up_clk,
  input logic           up_rstn,
  up_bus_fanin_if.slave bus
);

  logic [31:0]      rdata_p;
  logic             rack_p, wack_p;
  logic             r_ack, r_to, r_late;
  logic             w_ack, w_to, w_late;
  logic             coll;
  logic [ERR_W-1:0] err_set, err_q;

  if (PIPE_STAGES == 1) begin : g_pipe1
    logic [31:0] rdata_or;

    always_comb begin
      rdata_or = '0;
      for (int s = 0; s < NUM_SLAVES; s++)
        rdata_or = rdata_or | bus.up_rdata_s[s*32 +: 32];
    end

    always_ff @(posedge up_clk or negedge up_rstn) begin
      if (!up_rstn) begin
        rdata_p <= '0;
        rack_p  <= 1'b0;
        wack_p  <= 1'b0;
      end else begin
        rdata_p <= rdata_or;
        rack_p  <= |bus.up_rack_s;
        wack_p  <= |bus.up_wack_s;
      end
    end
  end else begin : g_pipe2
    localparam int NG = (NUM_SLAVES + 7) / 8;
    logic [NG*32-1:0] grp_rdata_d, grp_rdata_q;
    logic [NG-1:0]    grp_rack_d, grp_rack_q, grp_wack_d, grp_wack_q;
    logic [31:0]      rdata_or;

    // stage 1: groups of eight slaves, the last group possibly partial
    always_comb begin
      grp_rdata_d = '0;
      grp_rack_d  = '0;
      grp_wack_d  = '0;
      for (int s = 0; s < NUM_SLAVES; s++) begin
        grp_rdata_d[(s/8)*32 +: 32] = grp_rdata_d[(s/8)*32 +: 32] | bus.up_rdata_s[s*32 +: 32];
        grp_rack_d[s/8] = grp_rack_d[s/8] | bus.up_rack_s[s];
        grp_wack_d[s/8] = grp_wack_d[s/8] | bus.up_wack_s[s];
      end
    end

    always_comb begin
      rdata_or = '0;
      for (int g = 0; g < NG; g++)
        rdata_or = rdata_or | grp_rdata_q[g*32 +: 32];
    end

    always_ff @(posedge up_clk or negedge up_rstn) begin
      if (!up_rstn) begin
        grp_rdata_q <= '0;
        grp_rack_q  <= '0;
        grp_wack_q  <= '0;
        rdata_p     <= '0;
        rack_p      <= 1'b0;
        wack_p      <= 1'b0;
      end else begin
        grp_rdata_q <= grp_rdata_d;
        grp_rack_q  <= grp_rack_d;
        grp_wack_q  <= grp_wack_d;
        rdata_p     <= rdata_or;
        rack_p      <= |grp_rack_q;
        wack_p      <= |grp_wack_q;
      end
    end
  end

  up_bus_fanin_wdog #(.TIMEOUT(TIMEOUT)) u_wdog_rd (
    .clk     (up_clk),
    .rstn    (up_rstn),
    .req     (bus.up_rreq),
    .ack_in  (rack_p),
    .ack_out (r_ack),
    .timeout (r_to),
    .late    (r_late)
  );

  up_bus_fanin_wdog #(.TIMEOUT(TIMEOUT)) u_wdog_wr (
    .clk     (up_clk),
    .rstn    (up_rstn),
    .req     (bus.up_wreq),
    .ack_in  (wack_p),
    .ack_out (w_ack),
    .timeout (w_to),
    .late    (w_late)
  );

  // x & (x-1) is nonzero exactly when two or more bits are set
  assign coll = ((bus.up_rack_s & (bus.up_rack_s - NUM_SLAVES'(1))) != '0) ||
                ((bus.up_wack_s & (bus.up_wack_s - NUM_SLAVES'(1))) != '0);

  always_comb begin
    err_set                = '0;
    err_set[ERR_TIMEOUT]   = r_to | w_to;
    err_set[ERR_COLLISION] = coll;
    err_set[ERR_LATE]      = r_late | w_late;
  end

  always_ff @(posedge up_clk or negedge up_rstn) begin
    if (!up_rstn) err_q <= '0;
    else          err_q <= (err_q & ~bus.up_err_clr) | err_set;
  end

  assign bus.up_rack       = r_ack;
  assign bus.up_wack       = w_ack;
  assign bus.up_rdata      = r_to ? TIMEOUT_RDATA : (r_ack ? rdata_p : '0);
  assign bus.up_err_status = err_q;

endmodule

// File: tb/tb_up_bus_fanin.sv
// Directed bench for up_bus_fanin: a per-cycle vector table plus hand-written
// timeout, late-ack, pipelined-overlap, bypass and reset sequences.
`timescale 1ns/1ps
module tb_up_bus_fanin;
  import up_bus_fanin_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct packed {
    logic        rack;
    logic        wack;
    logic [31:0] rdata;
    logic [2:0]  err;
  } resp_t;

  typedef struct packed {
    logic         rreq;
    logic         wreq;
    logic [3:0]   rack_s;
    logic [3:0]   wack_s;
    logic [127:0] rdata_s;
    logic [2:0]   clr;
    resp_t        exp;
  } vec_t;

  up_bus_fanin_if #(.NUM_SLAVES(4))  ifa ();
  up_bus_fanin_if #(.NUM_SLAVES(20)) ifb ();
  up_bus_fanin_if #(.NUM_SLAVES(1))  ifc ();

  up_bus_fanin #(.NUM_SLAVES(4), .PIPE_STAGES(1), .TIMEOUT(16), .TIMEOUT_RDATA(32'hdead_dead))
    dut_a (.up_clk(clk), .up_rstn(rst_n), .bus(ifa.slave));
  up_bus_fanin #(.NUM_SLAVES(20), .PIPE_STAGES(2), .TIMEOUT(16), .TIMEOUT_RDATA(32'hdead_dead))
    dut_b (.up_clk(clk), .up_rstn(rst_n), .bus(ifb.slave));
  up_bus_fanin #(.NUM_SLAVES(1), .PIPE_STAGES(1), .TIMEOUT(0), .TIMEOUT_RDATA(32'hdead_dead))
    dut_c (.up_clk(clk), .up_rstn(rst_n), .bus(ifc.slave));

  function automatic resp_t rs(input logic rk, input logic wk, input logic [31:0] d, input logic [2:0] e);
    rs = {rk, wk, d, e};
  endfunction

  function automatic vec_t mk(input logic rq, input logic wq, input logic [3:0] rk, input logic [3:0] wk,
                              input logic [127:0] d, input logic [2:0] clr, input resp_t e);
    mk = {rq, wq, rk, wk, d, clr, e};
  endfunction

  function automatic resp_t get_a();
    get_a = {ifa.up_rack, ifa.up_wack, ifa.up_rdata, ifa.up_err_status};
  endfunction
  function automatic resp_t get_b();
    get_b = {ifb.up_rack, ifb.up_wack, ifb.up_rdata, ifb.up_err_status};
  endfunction
  function automatic resp_t get_c();
    get_c = {ifc.up_rack, ifc.up_wack, ifc.up_rdata, ifc.up_err_status};
  endfunction

  task automatic chk(input string name, input resp_t act, input resp_t exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got rack=%0b wack=%0b rdata=%h err=%b, expected rack=%0b wack=%0b rdata=%h err=%b",
               name, act.rack, act.wack, act.rdata, act.err, exp.rack, exp.wack, exp.rdata, exp.err);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic rq, input logic wq, input logic [3:0] rk, input logic [3:0] wk,
                         input logic [127:0] d, input logic [2:0] clr);
    ifa.up_rreq    = rq;
    ifa.up_wreq    = wq;
    ifa.up_rack_s  = rk;
    ifa.up_wack_s  = wk;
    ifa.up_rdata_s = d;
    ifa.up_err_clr = clr;
  endtask

  // read on dut_a with slave 1 acking at cycle ack_at (negative: never)
  task automatic rd_seq(input int ack_at, input logic [31:0] d);
    bit          timed_out = (ack_at < 0) || (ack_at >= 16);
    bit          is_late   = (ack_at >= 16);
    int          fire      = timed_out ? 16 : ack_at + 1;
    logic [31:0] fire_d    = timed_out ? 32'hdead_dead : d;
    logic [2:0]  e_err;
    for (int k = 0; k <= 21; k++) begin
      step();
      drive_a(k == 0, 1'b0, (k == ack_at) ? 4'b0010 : 4'b0000, 4'b0000,
              (k == ack_at) ? {64'h0, d, 32'h0} : 128'h0, 3'b000);
      @(negedge clk);
      e_err = {is_late && (k >= ack_at + 2), 1'b0, timed_out && (k >= 17)};
      chk($sformatf("rd_seq(%0d) k=%0d", ack_at, k), get_a(),
          rs(k == fire, 1'b0, (k == fire) ? fire_d : 32'h0, e_err));
    end
    step();
    drive_a(1'b0, 1'b0, 4'b0, 4'b0, 128'h0, 3'b111);
    step();
    drive_a(1'b0, 1'b0, 4'b0, 4'b0, 128'h0, 3'b000);
    @(negedge clk);
    chk($sformatf("rd_seq(%0d) cleared", ack_at), get_a(), rs(1'b0, 1'b0, 32'h0, 3'b000));
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not reach its end, limit 500000 ns");
    $fatal(1, "bench time limit");
  end

  initial begin
    vec_t vecs[$];

    drive_a(1'b0, 1'b0, 4'b0, 4'b0, 128'h0, 3'b000);
    ifb.up_rreq = 1'b0; ifb.up_wreq = 1'b0; ifb.up_rack_s = '0; ifb.up_wack_s = '0;
    ifb.up_rdata_s = '0; ifb.up_err_clr = '0;
    ifc.up_rreq = 1'b0; ifc.up_wreq = 1'b0; ifc.up_rack_s = '0; ifc.up_wack_s = '0;
    ifc.up_rdata_s = '0; ifc.up_err_clr = '0;

    #2;
    chk("reset_a", get_a(), rs(1'b0, 1'b0, 32'h0, 3'b000));
    chk("reset_b", get_b(), rs(1'b0, 1'b0, 32'h0, 3'b000));
    #20 rst_n = 1'b1;

    // read/write, collision, set-vs-clear and spurious-ack vectors on dut_a
    vecs.push_back(mk(1, 0, 4'b0000, 4'b0000, 128'h0, 3'b000, rs(0, 0, 32'h0, 3'b000)));
    vecs.push_back(mk(0, 0, 4'b0000, 4'b0000, 128'h0, 3'b000, rs(0, 0, 32'h0, 3'b000)));
    vecs.push_back(mk(0, 0, 4'b0000, 4'b0000, 128'h0, 3'b000, rs(0, 0, 32'h0, 3'b000)));
    vecs.push_back(mk(0, 0, 4'b0100, 4'b0000, {32'h0, 32'h1234_5678, 64'h0}, 3'b000, rs(0, 0, 32'h0, 3'b000)));
    vecs.push_back(mk(0, 0, 4'b0000, 4'b0000, 128'h0, 3'b000, rs(1, 0, 32'h1234_5678, 3'b000)));
    vecs.push_back(mk(0, 0, 4'b0000, 4'b0000, 128'h0, 3'b000, rs(0, 0, 32'h0, 3'b000)));
    vecs.push_back(mk(0, 1, 4'b0000, 4'b0000, 128'h0, 3'b000, rs(0, 0, 32'h0, 3'b000)));
    vecs.push_back(mk(0, 0, 4'b0000, 4'b0001, 128'h0, 3'b000, rs(0, 0, 32'h0, 3'b000)));
    vecs.push_back(mk(0, 0, 4'b0000, 4'b0000, 128'h0, 3'b000, rs(0, 1, 32'h0, 3'b000)));
    vecs.push_back(mk(0, 0, 4'b0000, 4'b0000, 128'h0, 3'b000, rs(0, 0, 32'h0, 3'b000)));
    vecs.push_back(mk(1, 0, 4'b0000, 4'b0000, 128'h0, 3'b000, rs(0, 0, 32'h0, 3'b000)));
    vecs.push_back(mk(0, 0, 4'b1001, 4'b0000, {32'h0000_00ff, 64'h0, 32'h00ff_0000}, 3'b000, rs(0, 0, 32'h0, 3'b000)));
    vecs.push_back(mk(0, 0, 4'b0000, 4'b0000, 128'h0, 3'b000, rs(1, 0, 32'h00ff_00ff, 3'b010)));
    vecs.push_back(mk(0, 0, 4'b0000, 4'b0000, 128'h0, 3'b000, rs(0, 0, 32'h0, 3'b010)));
    vecs.push_back(mk(0, 0, 4'b0000, 4'b0000, 128'h0, 3'b010, rs(0, 0, 32'h0, 3'b010)));
    vecs.push_back(mk(0, 0, 4'b0000, 4'b0000, 128'h0, 3'b000, rs(0, 0, 32'h0, 3'b000)));
    vecs.push_back(mk(1, 0, 4'b0000, 4'b0000, 128'h0, 3'b000, rs(0, 0, 32'h0, 3'b000)));
    vecs.push_back(mk(0, 0, 4'b0011, 4'b0000, {64'h0, 32'h0000_0f00, 32'h0000_000a}, 3'b010, rs(0, 0, 32'h0, 3'b000)));
    vecs.push_back(mk(0, 0, 4'b0000, 4'b0000, 128'h0, 3'b000, rs(1, 0, 32'h0000_0f0a, 3'b010)));
    vecs.push_back(mk(0, 0, 4'b0000, 4'b0000, 128'h0, 3'b010, rs(0, 0, 32'h0, 3'b010)));
    vecs.push_back(mk(0, 0, 4'b0000, 4'b0000, 128'h0, 3'b000, rs(0, 0, 32'h0, 3'b000)));
    vecs.push_back(mk(0, 0, 4'b0100, 4'b0000, {32'h0, 32'h5555_aaaa, 64'h0}, 3'b000, rs(0, 0, 32'h0, 3'b000)));
    vecs.push_back(mk(0, 0, 4'b0000, 4'b0000, 128'h0, 3'b000, rs(0, 0, 32'h0, 3'b000)));
    vecs.push_back(mk(0, 0, 4'b0000, 4'b0000, 128'h0, 3'b000, rs(0, 0, 32'h0, 3'b100)));
    vecs.push_back(mk(0, 0, 4'b0000, 4'b0000, 128'h0, 3'b100, rs(0, 0, 32'h0, 3'b100)));
    vecs.push_back(mk(0, 0, 4'b0000, 4'b0000, 128'h0, 3'b000, rs(0, 0, 32'h0, 3'b000)));

    foreach (vecs[i]) begin
      step();
      drive_a(vecs[i].rreq, vecs[i].wreq, vecs[i].rack_s, vecs[i].wack_s, vecs[i].rdata_s, vecs[i].clr);
      @(negedge clk);
      chk($sformatf("vec%0d", i), get_a(), vecs[i].exp);
    end

    // timeout, ack exactly at expiry, late ack after timeout, normal ack
    rd_seq(-1, 32'h0);
    rd_seq(15, 32'h0bad_cafe);
    rd_seq(18, 32'h0bad_cafe);
    rd_seq(4, 32'h7777_0001);

    // dut_b: 2-stage pipeline, read to slave 17 overlapping a write to slave 5
    for (int k = 0; k <= 22; k++) begin
      logic [639:0] d;
      step();
      d = '0;
      if (k == 3) d[17*32 +: 32] = 32'hcafe_f00d;
      ifb.up_wreq    = (k == 0);
      ifb.up_wack_s  = (k == 1) ? 20'h00020 : 20'h0;
      ifb.up_rreq    = (k == 2);
      ifb.up_rack_s  = (k == 3) ? 20'h20000 : 20'h0;
      ifb.up_rdata_s = d;
      @(negedge clk);
      chk($sformatf("pipe2 k=%0d", k), get_b(),
          rs(k == 5, k == 3, (k == 5) ? 32'hcafe_f00d : 32'h0, 3'b000));
    end

    // dut_c: watchdog disabled, unsolicited ack passes and no timeout ever
    for (int k = 0; k <= 19; k++) begin
      step();
      ifc.up_rreq    = (k == 2);
      ifc.up_rack_s  = (k == 0) ? 1'b1 : 1'b0;
      ifc.up_rdata_s = (k == 0) ? 32'h0000_beef : 32'h0;
      @(negedge clk);
      chk($sformatf("bypass k=%0d", k), get_c(),
          rs(k == 1, 1'b0, (k == 1) ? 32'h0000_beef : 32'h0, 3'b000));
    end

    // asynchronous reset during WAIT with cnt=7, after setting a sticky error
    step();
    drive_a(1'b0, 1'b0, 4'b0001, 4'b0, 128'h0, 3'b000);
    step();
    drive_a(1'b0, 1'b0, 4'b0000, 4'b0, 128'h0, 3'b000);
    for (int k = 0; k <= 8; k++) begin
      step();
      drive_a(k == 0, 1'b0, 4'b0, 4'b0, 128'h0, 3'b000);
    end
    @(negedge clk);
    chk("pre_reset", get_a(), rs(1'b0, 1'b0, 32'h0, 3'b100));
    #2 rst_n = 1'b0;
    #1;
    chk("in_reset", get_a(), rs(1'b0, 1'b0, 32'h0, 3'b000));
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      step();
      @(negedge clk);
      chk($sformatf("post_reset k=%0d", k), get_a(), rs(1'b0, 1'b0, 32'h0, 3'b000));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/up_bus_fanin.md
Name: up_bus_fanin

Overview:
- Parametrised up-bus response aggregator for register maps built from N up_* slaves: common, per-channel and TPL blocks.
- Sits between up_axi and the slaves.
- OR-reduces slave read data and acks through a configurable pipeline.
- Adds two checks: a per-direction watchdog that answers on behalf of a silent (unmapped) address, and sticky detection of decode collisions and late acks.

Parameters:
- NUM_SLAVES, 4, number of slave response ports (1..64)
- PIPE_STAGES, 1, response pipeline depth; 1 = single register, 2 = group-of-8 OR then final OR
- TIMEOUT, 256, cycles from req to forced ack; 0 disables watchdog
- TIMEOUT_RDATA, 32'hdead_dead, rdata returned on read timeout

Ports:
- up_clk  in  1  register bus clock
- up_rstn  in  1  asynchronous active-low reset
- up_wreq  in  1  write request pulse from up_axi
- up_rreq  in  1  read request pulse from up_axi
- up_wack_s  in  NUM_SLAVES  per-slave write ack
- up_rack_s  in  NUM_SLAVES  per-slave read ack
- up_rdata_s  in  NUM_SLAVES*32  per-slave read data, slave k at [k*32+:32]; 0 when not acking
- up_wack  out  1  aggregated write ack to up_axi
- up_rack  out  1  aggregated read ack to up_axi
- up_rdata  out  32  aggregated read data, valid with up_rack
- up_err_clr  in  3  write-1-to-clear for up_err_status bits
- up_err_status  out  3  sticky: [0] timeout, [1] collision, [2] late ack

Behaviour:
- Reset (up_rstn low, asynchronous): all outputs 0, pipeline registers 0, both watchdogs IDLE, counters 0.
- Datapath, PIPE_STAGES=1:
  - up_rdata <= OR of all up_rdata_s.
  - ack_r <= OR of up_rack_s; ack_w <= OR of up_wack_s.
  - Latency 1 cycle from slave ack.
- Datapath, PIPE_STAGES=2:
  - Stage 1 ORs slaves in groups of 8 (last group partial).
  - Stage 2 ORs the groups.
  - Latency 2 cycles.
  - Acks are delayed identically so data and ack stay aligned.
- Watchdog, one instance per direction (read and write are independent and may overlap). States:
  - IDLE: on req, go to WAIT; cnt <= 0.
  - WAIT: cnt increments every cycle.
    - If pipelined ack (ack_r/ack_w) is seen: forward it, go to IDLE.
    - Else if cnt == TIMEOUT-1: emit a one-cycle forced ack (up_rdata = TIMEOUT_RDATA for read, ignored for write), set err[0], go to IDLE.
- Simultaneous pipelined ack and expiry in the same cycle: the real ack wins; no error, slave data forwarded.
- Ack arriving while its watchdog is IDLE (late, after timeout, or spurious): suppressed (no up_rack/up_wack, up_rdata held 0), set err[2].
- Collision: two or more bits of up_rack_s, or of up_wack_s, high in the same cycle sets err[1]. The ack is still forwarded once; rdata is the OR.
- TIMEOUT=0: watchdog permanently passes acks through; err[0] and err[2] never set.
- Ack outputs are single-cycle pulses. up_rdata is 0 in every cycle where up_rack is 0.
- Sticky bits: cleared by up_err_clr[i]=1 for one cycle. Set and clear in the same cycle: set wins.
- Counter width: $clog2(TIMEOUT+1); no wrap is possible, since the counter stops at expiry.
- A req while the same-direction watchdog is in WAIT is a protocol violation (up_axi cannot issue one). It is ignored: the counter is not restarted.

Decomposition:
- Shared package:
  - error bit indices (ERR_TIMEOUT=0, ERR_COLLISION=1, ERR_LATE=2)
  - watchdog state encoding (IDLE/WAIT)
  - default TIMEOUT_RDATA
- Sub-module up_bus_fanin_wdog:
  - Instantiated twice (read, write).
  - Ports: clk, rstn, req, ack_in, ack_out, timeout, late.
- The OR tree and collision detect stay in the top level.

Test Plan:
1. NUM_SLAVES=4, PIPE_STAGES=1: rreq, slave 2 returns rack with rdata 32'h1234_5678 three cycles later -> up_rack pulses one cycle later with up_rdata 32'h1234_5678; err_status 0.
2. TIMEOUT=16: rreq, no slave responds -> up_rack at cycle 16 after rreq with up_rdata 32'hdead_dead; err_status 3'b001. Pulse up_err_clr=3'b001 -> status 0.
3. Slave acks on exactly the expiry cycle -> slave data returned, err_status stays 0. Slave acks two cycles after forced ack -> no up_rack, err_status[2]=1.
4. Slaves 0 and 3 rack simultaneously with 32'h00ff_0000 and 32'h0000_00ff -> single up_rack, up_rdata 32'h00ff_00ff, err_status[1]=1.
5. NUM_SLAVES=20, PIPE_STAGES=2: slave 17 racks 32'hcafe_f00d while a write to slave 5 is outstanding -> up_rack 2 cycles after slave ack with correct data; write watchdog unaffected; up_wack 2 cycles after slave 5 wack.
6. Deassert up_rstn while in WAIT with cnt=7 -> outputs 0 immediately. After release, no spurious ack and err_status 0 until the next req.
